// File: rtl/pew_target.sv
// pew_target: responder side of the pew trigger/echo link, emulating an
// ultrasonic range sensor. A trigger pulse that is long enough is answered,
// after a fixed burst delay, with an echo pulse whose width encodes the
// programmed target distance. A dead time follows each echo.
module pew_target #(
  parameter int MIN_TRIG   = 1000,
  parameter int HOLDOFF    = 50000,
  parameter int CYC_PER_CM = 5800,
  parameter int MAX_CM     = 400,
  parameter int TIMEOUT_CM = 650,
  parameter int COOLDOWN   = 6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [15:0] distance,
  output logic        echo,
  output logic        busy,
  output logic [3:0]  status
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TRIG     = 3'd1;
  localparam logic [2:0] S_HOLDOFF  = 3'd2;
  localparam logic [2:0] S_ECHO     = 3'd3;
  localparam logic [2:0] S_COOLDOWN = 3'd4;

  localparam int TRIG_W = (MIN_TRIG > 0) ? $clog2(MIN_TRIG + 1) : 1;
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int PRE_W  = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int CM_MAX = (MAX_CM > TIMEOUT_CM) ? MAX_CM : TIMEOUT_CM;
  localparam int CM_W   = ($clog2(CM_MAX + 1) > 16) ? $clog2(CM_MAX + 1) : 16;

  logic              trig_m;
  logic              trig_s;
  logic              trig_prev;
  logic              trig_rise;
  logic [2:0]        state;
  logic [TRIG_W-1:0] trig_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [CM_W-1:0]   cm_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic [CM_W-1:0]   target_cm;

  // Bring the asynchronous trigger pin into the clk domain and keep one
  // extra sample so a rising edge is only seen when the previous sample was 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m    <= 1'b0;
      trig_s    <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_m    <= trigger;
      trig_s    <= trig_m;
      trig_prev <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_prev;

  // Echo length in cm: out-of-range or zero distances report the no-target length.
  always_comb begin
    target_cm = CM_W'(TIMEOUT_CM);
    if ((distance != 16'd0) && (32'(distance) <= 32'(MAX_CM))) begin
      target_cm = CM_W'(distance);
    end
  end

  // Measurement sequencer: qualify trigger, wait out the burst, emit the echo
  // as cm count x prescaler, then hold off further triggers for the dead time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      echo     <= 1'b0;
      trig_cnt <= '0;
      hold_cnt <= '0;
      pre_cnt  <= '0;
      cm_cnt   <= '0;
      cool_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig_rise) begin
            state    <= S_TRIG;
            trig_cnt <= TRIG_W'(1);
          end
        end
        S_TRIG: begin
          if (trig_s) begin
            if (trig_cnt < TRIG_W'(MIN_TRIG)) begin
              trig_cnt <= trig_cnt + TRIG_W'(1);
            end
          end else if (trig_cnt >= TRIG_W'(MIN_TRIG)) begin
            state    <= S_HOLDOFF;
            hold_cnt <= '0;
            cm_cnt   <= target_cm;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == HOLD_W'(HOLDOFF)) begin
            state   <= S_ECHO;
            echo    <= 1'b1;
            pre_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_ECHO: begin
          if (pre_cnt == PRE_W'(CYC_PER_CM - 1)) begin
            pre_cnt <= '0;
            if (cm_cnt <= CM_W'(1)) begin
              state    <= S_COOLDOWN;
              echo     <= 1'b0;
              cool_cnt <= '0;
            end else begin
              cm_cnt <= cm_cnt - CM_W'(1);
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (cool_cnt == COOL_W'(COOLDOWN - 1)) begin
            state <= S_IDLE;
          end else begin
            cool_cnt <= cool_cnt + COOL_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          echo  <= 1'b0;
        end
      endcase
    end
  end

  // One-hot state indication and busy flag decoded from the state register.
  always_comb begin
    status = 4'b0000;
    busy   = 1'b0;
    case (state)
      S_TRIG:     status = 4'b0001;
      S_HOLDOFF:  begin status = 4'b0010; busy = 1'b1; end
      S_ECHO:     begin status = 4'b0100; busy = 1'b1; end
      S_COOLDOWN: begin status = 4'b1000; busy = 1'b1; end
      default:    status = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_pew_target.sv
// tb_pew_target: drives pew_target with directed and random trigger/distance
// waveforms, records inputs and outputs per cycle, then rebuilds the expected
// output history from the measurement rules and compares cycle by cycle.
module tb_pew_target;

  localparam int MIN_TRIG   = 10;
  localparam int HOLDOFF    = 5;
  localparam int CYC_PER_CM = 4;
  localparam int MAX_CM     = 400;
  localparam int TIMEOUT_CM = 500;
  localparam int COOLDOWN   = 20;
  localparam int DEPTH      = 60000;

  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_TRIG = 6'b000001;
  localparam logic [5:0] V_HOLD = 6'b010010;
  localparam logic [5:0] V_ECHO = 6'b110100;
  localparam logic [5:0] V_COOL = 6'b011000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] distance = 16'd0;
  logic        echo;
  logic        busy;
  logic [3:0]  status;

  pew_target #(
    .MIN_TRIG(MIN_TRIG), .HOLDOFF(HOLDOFF), .CYC_PER_CM(CYC_PER_CM),
    .MAX_CM(MAX_CM), .TIMEOUT_CM(TIMEOUT_CM), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .distance(distance),
    .echo(echo), .busy(busy), .status(status)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int cyc = 0;

  // Count active edges so each negedge sample can be tagged with its edge index
  always @(posedge clk) cyc <= cyc + 1;

  logic        pinHist[DEPTH];
  logic [15:0] dstHist[DEPTH];
  logic        rstHist[DEPTH];
  logic [5:0]  obsHist[DEPTH];
  logic [5:0]  expHist[DEPTH];
  int          lastCyc = 0;
  logic        overflow = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic tg, input logic [15:0] d, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cyc < DEPTH) begin
        obsHist[cyc] = {echo, busy, status};
        pinHist[cyc] = tg;
        dstHist[cyc] = d;
        rstHist[cyc] = r;
        lastCyc = cyc;
      end else begin
        overflow = 1'b1;
      end
      trigger  = tg;
      distance = d;
      rst      = r;
    end
  endtask

  task automatic triggerPulse(input int width, input logic [15:0] d, input int after);
    applyStimulus(1'b1, d, 1'b0, width);
    applyStimulus(1'b0, d, 1'b0, after);
  endtask

  // Synchronized trigger as seen by the responder at edge t (pin sampled three edges earlier)
  function automatic logic ts(input int t);
    return (t >= 3) ? pinHist[t-3] : 1'b0;
  endfunction

  task automatic fillPhase(input logic [5:0] val, input int start, input int len,
                           output int next, output logic ok);
    next = start;
    ok = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (ok) begin
        if (next > lastCyc || rstHist[next-1]) ok = 1'b0;
        else begin
          expHist[next] = val;
          next++;
        end
      end
    end
  endtask

  task automatic buildExpected();
    int t, f, u, k, n;
    logic ok;
    t = 1;
    while (t <= lastCyc) begin
      if (rstHist[t-1]) begin
        expHist[t] = V_IDLE;
        t++;
      end else if (ts(t) && !ts(t-1)) begin
        expHist[t] = V_TRIG;
        f = t + 1;
        while (f <= lastCyc && !rstHist[f-1] && ts(f)) begin
          expHist[f] = V_TRIG;
          f++;
        end
        if (f > lastCyc || rstHist[f-1]) begin
          t = f;
        end else begin
          k = f - t;
          if (k >= MIN_TRIG) begin
            n = (dstHist[f-1] >= 1 && dstHist[f-1] <= MAX_CM) ? int'(dstHist[f-1]) : TIMEOUT_CM;
            fillPhase(V_HOLD, f, HOLDOFF + 1, u, ok);
            if (ok) fillPhase(V_ECHO, u, n * CYC_PER_CM, u, ok);
            if (ok) fillPhase(V_COOL, u, COOLDOWN, u, ok);
            if (ok && u <= lastCyc) begin
              expHist[u] = V_IDLE;
              u++;
            end
            t = u;
          end else begin
            expHist[f] = V_IDLE;
            t = f + 1;
          end
        end
      end else begin
        expHist[t] = V_IDLE;
        t++;
      end
    end
  endtask

  initial begin
    int gap, width, r;
    logic [15:0] d;
    pinHist[0] = 1'b0;
    dstHist[0] = 16'd0;
    rstHist[0] = 1'b1;

    // reset, then idle
    applyStimulus(1'b0, 16'd0, 1'b1, 4);
    applyStimulus(1'b0, 16'd0, 1'b0, 5);

    // normal measurement
    triggerPulse(12, 16'd25, 160);

    // runt then exact-minimum trigger
    triggerPulse(9, 16'd25, 20);
    triggerPulse(10, 16'd7, 80);

    // no-target measurements
    triggerPulse(12, 16'd0, 2060);
    triggerPulse(12, 16'd401, 2060);

    // distance change during echo does not affect the running echo
    triggerPulse(12, 16'd25, 30);
    applyStimulus(1'b0, 16'd3, 1'b0, 130);

    // pulses during cooldown are ignored
    triggerPulse(12, 16'd5, 32);
    triggerPulse(12, 16'd5, 3);
    triggerPulse(3, 16'd5, 40);

    // trigger held across cooldown exit needs a fresh edge
    triggerPulse(12, 16'd5, 32);
    triggerPulse(40, 16'd5, 10);
    triggerPulse(12, 16'd6, 80);

    // reset 40 cycles into echo; echo must drop without a clock edge
    triggerPulse(12, 16'd25, 49);
    applyStimulus(1'b0, 16'd25, 1'b1, 1);
    #1;
    checkOutput("async_reset", {echo, busy, status}, V_IDLE);
    applyStimulus(1'b0, 16'd25, 1'b1, 3);
    applyStimulus(1'b0, 16'd1, 1'b0, 5);
    triggerPulse(12, 16'd1, 60);

    // max range
    triggerPulse(12, 16'd400, 1660);

    // random trigger/distance activity
    for (int i = 0; i < 150; i++) begin
      gap   = int'($urandom_range(1, 30));
      width = int'($urandom_range(1, 14));
      r     = int'($urandom_range(0, 49));
      if (r == 0) d = 16'd0;
      else if (r == 1) d = 16'(401 + $urandom_range(0, 100));
      else d = 16'($urandom_range(1, 30));
      applyStimulus(1'b0, d, 1'b0, gap);
      applyStimulus(1'b1, d, 1'b0, width);
    end
    applyStimulus(1'b0, 16'd10, 1'b0, 50);

    buildExpected();
    for (int t = 1; t <= lastCyc; t++) begin
      checkOutput($sformatf("cycle%0d", t), obsHist[t], expHist[t]);
    end
    checkOutput("history_depth", {5'b0, overflow}, 6'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
